// File: rtl/blank_scheduler.sv
// rtl/blank_scheduler.sv - blanking-window arbiter for the sprite/register update port
//
// Shares one update port between NUM_REQ requesters and issues grants only
// while the raster is in horizontal or vertical blanking. Each grant is
// limited to MAX_BURST pixel ticks and is revoked if active video begins.
//
// Optional feature macro: BLANK_SCHED_RR_EN
//   defined   - round-robin selection; the requester after the last one granted
//               has highest priority
//   undefined - fixed priority, lowest index wins
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   pix_tick       pixel advance strobe (timing counter enable)
//   hblank         horizontal blank (h_counter < 0)
//   vblank         vertical blank
//   vblank_last    final vblank line; only the hblank window applies on it
//   h_counter      signed horizontal counter, 0 = first visible pixel
//   req            level requests, held for the whole access
//   grant          registered one-hot (or zero) grant
//   busy           registered |grant
//   timeout        one-cycle pulse when the burst limit revokes a grant
//   overrun        sticky flag, grant revoked on active-video entry
//   clear_overrun  synchronous clear of overrun (a new set wins)
module blank_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 8,
    parameter int HW        = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pix_tick,
    input  logic                 hblank,
    input  logic                 vblank,
    input  logic                 vblank_last,
    input  logic signed [HW:0]   h_counter,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout,
    output logic                 overrun,
    input  logic                 clear_overrun
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Latest hblank position that still leaves room for a full burst.
    localparam logic signed [HW:0] H_LIMIT = (HW+1)'(-MAX_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   sel;
    logic [7:0]         burst_cnt;

    logic               window_open;
    logic               any_req;
    logic [IDX_W-1:0]   pick;
    logic               req_drop;
    logic               burst_hit;
    logic               active_video;

    assign window_open  = (vblank && !vblank_last) || (hblank && (h_counter <= H_LIMIT));
    assign any_req      = |req;
    assign req_drop     = !req[sel];
    // True on the tick that brings the count up to MAX_BURST.
    assign burst_hit    = pix_tick && (burst_cnt == 8'(MAX_BURST - 1));
    assign active_video = !hblank && !vblank;

`ifdef BLANK_SCHED_RR_EN
    logic [IDX_W-1:0]   rr_ptr;
    int                 idx;

    // Scan from the highest offset down so the nearest requester after
    // rr_ptr is the last (winning) assignment.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                pick = IDX_W'(idx);
            end
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sel       <= '0;
            burst_cnt <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
`ifdef BLANK_SCHED_RR_EN
            rr_ptr    <= '0;
`endif
        end else begin
            timeout <= 1'b0;

            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (window_open && any_req) begin
                        sel   <= pick;
                        grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        busy  <= 1'b1;
                        state <= GRANT;
`ifdef BLANK_SCHED_RR_EN
                        rr_ptr <= (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
`endif
                    end
                end

                GRANT: begin
                    if (pix_tick) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                    if (req_drop || burst_hit || active_video) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        state   <= RELEASE;
                        // A requester that lets go on the limit tick released normally.
                        timeout <= !req_drop && burst_hit;
                    end
                end

                RELEASE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase

            // Set has priority over clear so a revocation is never lost.
            if (state == GRANT && active_video) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blank_scheduler.sv
// tb/tb_blank_scheduler.sv - directed table-driven bench for blank_scheduler
module tb_blank_scheduler;

`ifdef BLANK_SCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               pix_tick;
    logic               hblank;
    logic               vblank;
    logic               vblank_last;
    logic signed [10:0] h_counter;
    logic [2:0]         req;
    logic [2:0]         grant;
    logic               busy;
    logic               timeout;
    logic               overrun;
    logic               clear_overrun;

    int checks   = 0;
    int failures = 0;

    blank_scheduler #(
        .NUM_REQ   (3),
        .MAX_BURST (8),
        .HW        (10)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pix_tick      (pix_tick),
        .hblank        (hblank),
        .vblank        (vblank),
        .vblank_last   (vblank_last),
        .h_counter     (h_counter),
        .req           (req),
        .grant         (grant),
        .busy          (busy),
        .timeout       (timeout),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vb;
        logic       vbl;
        logic       hb;
        int         hc;
        logic [2:0] rq;
        logic       pt;
        logic       clr;
        logic [2:0] eg;
        logic       et;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic vb, logic vbl, logic hb, int hc, logic [2:0] rq,
                                logic pt, logic clr, logic [2:0] eg, logic et, logic eo);
        vec_t v;
        v.vb = vb; v.vbl = vbl; v.hb = hb; v.hc = hc; v.rq = rq;
        v.pt = pt; v.clr = clr; v.eg = eg; v.et = et; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        vblank        = v.vb;
        vblank_last   = v.vbl;
        hblank        = v.hb;
        h_counter     = 11'(v.hc);
        req           = v.rq;
        pix_tick      = v.pt;
        clear_overrun = v.clr;
    endtask

    logic [2:0] fair_exp [4];
    logic [2:0] g;
    bit         seen;

    initial begin
        reset_n = 1'b0;
        drive(mk(0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", 8'(grant), 8'd0);
        chk("reset_busy", 8'(busy), 8'd0);
        chk("reset_timeout", 8'(timeout), 8'd0);
        chk("reset_overrun", 8'(overrun), 8'd0);
        reset_n = 1'b1;

        // vblank grant, release and three-cycle regrant
        vecs.push_back(mk(1, 0, 0,   0, 3'b110, 0, 0, 3'b010, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b110, 0, 0, 3'b010, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b100, 0, 0, 3'b000, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b100, 0, 0, 3'b000, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b100, 0, 0, 3'b100, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b000, 0, 0, 3'b000, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b000, 0, 0, 3'b000, 0, 0));
        // hblank window edge at -MAX_BURST
        vecs.push_back(mk(0, 0, 1,  -7, 3'b001, 0, 0, 3'b000, 0, 0));
        vecs.push_back(mk(0, 0, 1,  -7, 3'b001, 0, 0, 3'b000, 0, 0));
        vecs.push_back(mk(0, 0, 1,  -8, 3'b001, 0, 0, 3'b001, 0, 0));
        vecs.push_back(mk(0, 0, 1,  -5, 3'b001, 0, 0, 3'b001, 0, 0));
        // overrun on active video, sticky until clear
        vecs.push_back(mk(0, 0, 0,   0, 3'b001, 0, 0, 3'b000, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 3'b000, 0, 0, 3'b000, 0, 1));
        vecs.push_back(mk(0, 0, 0,   0, 3'b000, 0, 1, 3'b000, 0, 0));
        // set and clear in the same cycle: set wins
        vecs.push_back(mk(1, 0, 0,   0, 3'b001, 0, 0, 3'b001, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0, 3'b001, 0, 1, 3'b000, 0, 1));
        vecs.push_back(mk(1, 0, 0,   0, 3'b000, 0, 0, 3'b000, 0, 1));
        vecs.push_back(mk(1, 0, 0,   0, 3'b000, 0, 1, 3'b000, 0, 0));
        // burst limit timeout with requester 1 waiting
        vecs.push_back(mk(1, 0, 0,   0, 3'b001, 1, 0, 3'b001, 0, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1, 0, 0, 0, 3'b011, 1, 0, 3'b001, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b011, 1, 0, 3'b000, 1, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b011, 0, 0, 3'b000, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b011, 0, 0, RR ? 3'b010 : 3'b001, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b000, 0, 0, 3'b000, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 3'b000, 0, 0, 3'b000, 0, 0));
        // last vblank line: only the hblank window applies
        vecs.push_back(mk(1, 1, 0,   0, 3'b001, 0, 0, 3'b000, 0, 0));
        vecs.push_back(mk(1, 1, 1, -10, 3'b001, 0, 0, 3'b001, 0, 0));
        // request drop on the limit tick is a normal release
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1, 1, 1, -10, 3'b001, 1, 0, 3'b001, 0, 0));
        vecs.push_back(mk(1, 1, 1, -10, 3'b000, 1, 0, 3'b000, 0, 0));
        vecs.push_back(mk(1, 1, 1, -10, 3'b000, 0, 0, 3'b000, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            chk($sformatf("row%0d_grant", i), 8'(grant), 8'(vecs[i].eg));
            chk($sformatf("row%0d_busy", i), 8'(busy), 8'(|vecs[i].eg));
            chk($sformatf("row%0d_timeout", i), 8'(timeout), 8'(vecs[i].et));
            chk($sformatf("row%0d_overrun", i), 8'(overrun), 8'(vecs[i].eo));
        end

        // Asynchronous reset in the middle of a grant to requester 1
        drive(mk(1, 0, 0, 0, 3'b001, 0, 0, 3'b000, 0, 0));
        step();
        drive(mk(0, 0, 0, 0, 3'b001, 0, 0, 3'b000, 0, 0));
        step();
        drive(mk(1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0));
        step();
        step();
        drive(mk(1, 0, 0, 0, 3'b010, 0, 0, 3'b000, 0, 0));
        step();
        chk("pre_reset_grant", 8'(grant), 8'b010);
        chk("pre_reset_overrun", 8'(overrun), 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_grant", 8'(grant), 8'd0);
        chk("async_reset_busy", 8'(busy), 8'd0);
        chk("async_reset_timeout", 8'(timeout), 8'd0);
        chk("async_reset_overrun", 8'(overrun), 8'd0);
        drive(mk(1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Fairness: every requester holds two cycles, releases, re-requests
        fair_exp[0] = 3'b001;
        fair_exp[1] = RR ? 3'b010 : 3'b001;
        fair_exp[2] = RR ? 3'b100 : 3'b001;
        fair_exp[3] = 3'b001;
        for (int n = 0; n < 4; n++) begin
            req  = 3'b111;
            seen = 1'b0;
            for (int w = 0; w < 6 && !seen; w++) begin
                step();
                if (grant != 3'b000) seen = 1'b1;
            end
            g = grant;
            chk($sformatf("fair%0d_grant", n), 8'(g), 8'(fair_exp[n]));
            step();
            chk($sformatf("fair%0d_hold", n), 8'(grant), 8'(fair_exp[n]));
            req = 3'b111 & ~g;
            step();
            chk($sformatf("fair%0d_release", n), 8'(grant), 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
